keystream_xor: RTL

Stream-cipher combiner that sits directly downstream of the LFSR keystream generator. It accepts keystream words of KS_WIDTH bits and buffers them in a bit reservoir. It splits the buffered bits into bytes and XORs one keystream byte with each plaintext byte to produce ciphertext. The same block decrypts, because XOR is its own inverse. Every input and output path uses a valid/ready handshake, so the LFSR can run ahead of the data path and the data path can stall.

---
 rtl/keystream_xor.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/keystream_xor.sv
// keystream_xor: stream-cipher combiner.
// Buffers keystream words in a left-aligned bit reservoir and XORs one
// keystream byte into each plaintext byte. The same path decrypts.
// Optional feature macro: KSX_COUNT_EN adds the 16-bit byte_count output.
// Reset is asynchronous and active-low on port 'reset'.
module keystream_xor #(
  parameter int KS_WIDTH = 22,
  parameter int BUF_BITS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [KS_WIDTH-1:0] ks_word,
  input  logic                ks_valid,
  output logic                ks_ready,
  input  logic                flush,
  input  logic [7:0]          pt_data,
  input  logic                pt_valid,
  output logic                pt_ready,
  output logic [7:0]          ct_data,
  output logic                ct_valid,
  input  logic                ct_ready
`ifdef KSX_COUNT_EN
  ,
  output logic [15:0]         byte_count
`endif
);

  // Counter width holds 0..BUF_BITS; comparisons use one extra bit so that
  // cnt + KS_WIDTH cannot overflow.
  localparam int CW  = $clog2(BUF_BITS + 1);
  localparam int CW1 = CW + 1;
  localparam int PAD = BUF_BITS - KS_WIDTH;

  localparam logic [CW1-1:0] KS_W  = CW1'(KS_WIDTH);
  localparam logic [CW1-1:0] BUF_W = CW1'(BUF_BITS);
  localparam logic [CW-1:0]  BYTE  = CW'(8);
  localparam logic [CW-1:0]  KS_C  = CW'(KS_WIDTH);

  // State
  logic [BUF_BITS-1:0] buf_reg;
  logic [BUF_BITS-1:0] buf_next;
  logic [CW-1:0]       cnt_reg;
  logic [CW-1:0]       cnt_next;
  logic                run_reg;
  logic [7:0]          ct_data_reg;
  logic [7:0]          ct_data_next;
  logic                ct_valid_reg;
  logic                ct_valid_next;

  // Handshake and datapath helpers
  logic                ks_fire;
  logic                pt_fire;
  logic                ct_take;
  logic [7:0]          ks_byte;
  logic [BUF_BITS-1:0] buf_shift;
  logic [CW-1:0]       cnt_shift;
  logic [BUF_BITS-1:0] ks_placed;
  logic [BUF_BITS-1:0] keep_mask;

  // ks_ready looks at the pre-shift count: a word is only taken when it would
  // fit even without the same-cycle byte consumption, so nothing is dropped.
  assign ks_ready = run_reg & (({1'b0, cnt_reg} + KS_W) <= BUF_W);
  assign pt_ready = run_reg & ~flush & (cnt_reg >= BYTE) &
                    (~ct_valid_reg | ct_ready);

  assign ks_fire = ks_valid & ks_ready;
  assign pt_fire = pt_valid & pt_ready;
  assign ct_take = ct_valid_reg & ct_ready;

  // Oldest eight buffered bits form the next keystream byte.
  assign ks_byte = buf_reg[BUF_BITS-1 -: 8];

  assign ct_data  = ct_data_reg;
  assign ct_valid = ct_valid_reg;

  // Post-consumption view of the reservoir: the append is applied on top.
  assign buf_shift = pt_fire ? (buf_reg << 8) : buf_reg;
  assign cnt_shift = pt_fire ? (cnt_reg - BYTE) : cnt_reg;

  // New word left-aligned, then moved down to sit right after valid bits.
  assign ks_placed = {ks_word, {PAD{1'b0}}} >> cnt_shift;

  // Per-bit mask of the bits still valid after the shift (top cnt_shift bits).
  genvar gi;
  generate
    for (gi = 0; gi < BUF_BITS; gi++) begin : g_keep
      assign keep_mask[gi] = (CW1'(BUF_BITS - 1 - gi) < {1'b0, cnt_shift});
    end
  endgenerate

  // Reservoir next-state: flush wins, otherwise shift then append.
  always_comb begin
    buf_next = buf_shift;
    cnt_next = cnt_shift;
    if (flush) begin
      buf_next = '0;
      cnt_next = '0;
    end else if (ks_fire) begin
      buf_next = (buf_shift & keep_mask) | ks_placed;
      cnt_next = cnt_shift + KS_C;
    end
  end

  // Output register next-state: a new byte replaces, an accept alone clears.
  always_comb begin
    ct_data_next  = ct_data_reg;
    ct_valid_next = ct_valid_reg;
    if (pt_fire) begin
      ct_data_next  = pt_data ^ ks_byte;
      ct_valid_next = 1'b1;
    end else if (ct_take) begin
      ct_valid_next = 1'b0;
    end
  end

  // run holds both ready outputs low through the first edge after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_reg <= 1'b0;
    end else begin
      run_reg <= 1'b1;
    end
  end

  // Reservoir bits and valid-bit count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_reg <= '0;
      cnt_reg <= '0;
    end else begin
      buf_reg <= buf_next;
      cnt_reg <= cnt_next;
    end
  end

  // Registered result byte; no combinational path from pt_data to ct_data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ct_data_reg  <= 8'h00;
      ct_valid_reg <= 1'b0;
    end else begin
      ct_data_reg  <= ct_data_next;
      ct_valid_reg <= ct_valid_next;
    end
  end

`ifdef KSX_COUNT_EN
  logic [15:0] byte_count_reg;

  // Completed-byte counter; wraps naturally and ignores flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_count_reg <= 16'h0000;
    end else if (pt_fire) begin
      byte_count_reg <= byte_count_reg + 16'h0001;
    end
  end

  assign byte_count = byte_count_reg;
`endif

endmodule
